// File: rtl/seq_gen_pkg.sv
// Shared defaults and FSM encoding for the serial pattern generator controller.
package seq_gen_pkg;

    localparam int CHAIN_W_DEF = 12;
    localparam int LEN_W_DEF   = 4;
    localparam int REP_W_DEF   = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_gen_ctrl.sv
// Serialises a latched pattern MSB-first into a shift chain, repeating it
// a programmed number of times (or forever) with abort and done signalling.
module seq_gen_ctrl
    import seq_gen_pkg::*;
#(
    parameter int CHAIN_W = CHAIN_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int REP_W   = REP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CHAIN_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [REP_W-1:0]   cfg_reps,
    input  logic               abort,
    output logic               ser_o,
    output logic               shift_en,
    output logic               busy,
    output logic               done,
    output logic [LEN_W-1:0]   bit_idx,
    output logic [REP_W-1:0]   rep_cnt
);

    // cfg handshake: a configuration transfers on a rising edge where
    // cfg_valid && cfg_ready; cfg_ready is high only in IDLE, so offers made
    // during RUN/DONE simply wait and are never latched early.

    state_t             state;
    logic [CHAIN_W-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [REP_W-1:0]   reps_q;

    logic [LEN_W-1:0]   cfg_len_eff;
    logic [LEN_W-1:0]   first_idx;
    logic [LEN_W-1:0]   wrap_idx;
    logic [LEN_W-1:0]   next_idx;
    logic               last_bit;
    logic               last_rep;

    assign cfg_ready = (state == S_IDLE);

    // Length 0 selects the full chain; out-of-range lengths are clamped too.
    always_comb begin
        cfg_len_eff = cfg_len;
        if (cfg_len == '0 || cfg_len > LEN_W'(CHAIN_W))
            cfg_len_eff = LEN_W'(CHAIN_W);
    end

    assign first_idx = cfg_len_eff - LEN_W'(1);
    assign wrap_idx  = len_q - LEN_W'(1);
    assign next_idx  = len_q - bit_idx - LEN_W'(2);
    assign last_bit  = (bit_idx == wrap_idx);
    assign last_rep  = (reps_q != '0) && (rep_cnt == reps_q - REP_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pat_q    <= '0;
            len_q    <= '0;
            reps_q   <= '0;
            ser_o    <= 1'b0;
            shift_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bit_idx  <= '0;
            rep_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        pat_q    <= cfg_pattern;
                        len_q    <= cfg_len_eff;
                        reps_q   <= cfg_reps;
                        bit_idx  <= '0;
                        rep_cnt  <= '0;
                        ser_o    <= cfg_pattern[first_idx];
                        shift_en <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Abort wins even over completion on the final bit.
                    if (abort) begin
                        shift_en <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (last_bit) begin
                        bit_idx <= '0;
                        rep_cnt <= rep_cnt + REP_W'(1);
                        if (last_rep) begin
                            shift_en <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            ser_o <= pat_q[wrap_idx];
                        end
                    end else begin
                        bit_idx <= bit_idx + LEN_W'(1);
                        ser_o   <= pat_q[next_idx];
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    shift_en <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// Self-checking bench for seq_gen_ctrl: expected serial bits are queued when
// a configuration is driven and popped as shift_en cycles appear.
module tb_seq_gen_ctrl;
    import seq_gen_pkg::*;

    localparam int CHAIN_W = CHAIN_W_DEF;
    localparam int LEN_W   = LEN_W_DEF;
    localparam int REP_W   = REP_W_DEF;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CHAIN_W-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic [REP_W-1:0]   cfg_reps;
    logic               abort;
    logic               ser_o;
    logic               shift_en;
    logic               busy;
    logic               done;
    logic [LEN_W-1:0]   bit_idx;
    logic [REP_W-1:0]   rep_cnt;

    logic [0:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    seq_gen_ctrl #(.CHAIN_W(CHAIN_W), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_reps(cfg_reps),
        .abort(abort), .ser_o(ser_o), .shift_en(shift_en), .busy(busy),
        .done(done), .bit_idx(bit_idx), .rep_cnt(rep_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, compared %0d mismatched %0d", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic push_exp(input logic [CHAIN_W-1:0] p, input int len, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < len; i++)
                exp_q.push_back(p[len-1-i]);
    endtask

    task automatic start_cfg(input logic [CHAIN_W-1:0] p, input logic [LEN_W-1:0] l,
                             input logic [REP_W-1:0] r);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_reps    = r;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
    endtask

    function automatic int eff_len(input int l);
        return (l == 0 || l > CHAIN_W) ? CHAIN_W : l;
    endfunction

    task automatic test_reset();
        repeat (2) tick();
        n_cmp++;
        if ({ser_o, shift_en, busy, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got %b required 0000", {ser_o, shift_en, busy, done});
        end
        n_cmp++;
        if (bit_idx !== '0 || rep_cnt !== '0 || cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_cnt: got idx %0d rep %0d rdy %b required 0 0 1", bit_idx, rep_cnt, cfg_ready);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (shift_en !== 1'b0 || cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: got en %b rdy %b required 0 1", shift_en, cfg_ready);
        end
    endtask

    task automatic test_finite();
        logic [0:0] e;
        push_exp(12'b000000101101, 6, 2);
        start_cfg(12'b000000101101, 4'd6, 8'd2);
        for (int i = 0; i < 12; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (shift_en !== 1'b1 || ser_o !== e) begin
                n_err++;
                $display("FAIL finite_bit%0d: got en %b ser %b required 1 %b", i, shift_en, ser_o, e);
            end
            n_cmp++;
            if (bit_idx !== LEN_W'(i % 6) || rep_cnt !== REP_W'(i / 6) || cfg_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL finite_cnt%0d: got idx %0d rep %0d rdy %b busy %b required %0d %0d 0 1",
                         i, bit_idx, rep_cnt, cfg_ready, busy, i % 6, i / 6);
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || shift_en !== 1'b0 || busy !== 1'b0 || ser_o !== 1'b1 || rep_cnt !== REP_W'(2)) begin
            n_err++;
            $display("FAIL finite_done: got done %b en %b busy %b ser %b rep %0d required 1 0 0 1 2",
                     done, shift_en, busy, ser_o, rep_cnt);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || cfg_ready !== 1'b1 || shift_en !== 1'b0) begin
            n_err++;
            $display("FAIL finite_idle: got done %b rdy %b en %b required 0 1 0", done, cfg_ready, shift_en);
        end
    endtask

    task automatic test_len0();
        logic [0:0] e;
        push_exp(12'hA5C, 12, 1);
        start_cfg(12'hA5C, 4'd0, 8'd1);
        for (int i = 0; i < 12; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (shift_en !== 1'b1 || ser_o !== e) begin
                n_err++;
                $display("FAIL len0_bit%0d: got en %b ser %b required 1 %b", i, shift_en, ser_o, e);
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || shift_en !== 1'b0) begin
            n_err++;
            $display("FAIL len0_done: got done %b en %b required 1 0", done, shift_en);
        end
        tick();
    endtask

    task automatic test_abort_continuous();
        logic [0:0] e;
        push_exp(12'b110, 3, 10);
        start_cfg(12'b110, 4'd3, 8'd0);
        for (int i = 0; i < 30; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (shift_en !== 1'b1 || ser_o !== e || rep_cnt !== REP_W'(i / 3)) begin
                n_err++;
                $display("FAIL cont_bit%0d: got en %b ser %b rep %0d required 1 %b %0d",
                         i, shift_en, ser_o, rep_cnt, e, i / 3);
            end
            if (i == 29) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (shift_en !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL cont_abort%0d: got en %b done %b rdy %b busy %b required 0 0 1 0",
                         i, shift_en, done, cfg_ready, busy);
            end
            tick();
        end
    endtask

    task automatic test_len1_wrap();
        logic [CHAIN_W-1:0] p;
        logic [0:0] e;
        p = CHAIN_W'($urandom_range(0, 4095));
        push_exp(p, 1, 260);
        start_cfg(p, 4'd1, 8'd0);
        for (int i = 0; i < 260; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (shift_en !== 1'b1 || ser_o !== e || bit_idx !== '0 || rep_cnt !== REP_W'(i % 256)) begin
                n_err++;
                $display("FAIL len1_cyc%0d: got en %b ser %b idx %0d rep %0d required 1 %b 0 %0d",
                         i, shift_en, ser_o, bit_idx, rep_cnt, e, i % 256);
            end
            if (i == 259) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        n_cmp++;
        if (shift_en !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL len1_abort: got en %b done %b rdy %b required 0 0 1", shift_en, done, cfg_ready);
        end
        tick();
    endtask

    task automatic test_cfg_while_busy();
        logic [CHAIN_W-1:0] pa, pb;
        int lb, rb;
        logic [0:0] e;
        pa = CHAIN_W'($urandom_range(0, 4095));
        pb = CHAIN_W'($urandom_range(0, 4095));
        lb = $urandom_range(1, 12);
        rb = $urandom_range(1, 2);
        push_exp(pa, 4, 3);
        cfg_pattern = pa; cfg_len = 4'd4; cfg_reps = 8'd3; cfg_valid = 1'b1;
        tick();
        cfg_pattern = pb; cfg_len = LEN_W'(lb); cfg_reps = REP_W'(rb);
        for (int i = 0; i < 12; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (shift_en !== 1'b1 || ser_o !== e || cfg_ready !== 1'b0) begin
                n_err++;
                $display("FAIL busy_bit%0d: got en %b ser %b rdy %b required 1 %b 0", i, shift_en, ser_o, cfg_ready, e);
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || cfg_ready !== 1'b0) begin
            n_err++;
            $display("FAIL busy_done: got done %b rdy %b required 1 0", done, cfg_ready);
        end
        tick();
        n_cmp++;
        if (cfg_ready !== 1'b1 || shift_en !== 1'b0) begin
            n_err++;
            $display("FAIL busy_idle: got rdy %b en %b required 1 0", cfg_ready, shift_en);
        end
        push_exp(pb, lb, rb);
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < lb * rb; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (shift_en !== 1'b1 || ser_o !== e) begin
                n_err++;
                $display("FAIL busy_new%0d: got en %b ser %b required 1 %b", i, shift_en, ser_o, e);
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL busy_new_done: got %b required 1", done);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        start_cfg(CHAIN_W'($urandom_range(0, 4095)), 4'd8, 8'd4);
        repeat (5) tick();
        n_cmp++;
        if (bit_idx !== LEN_W'(5) || shift_en !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pos: got idx %0d en %b required 5 1", bit_idx, shift_en);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ser_o, shift_en, busy, done} !== 4'b0000 || bit_idx !== '0 || rep_cnt !== '0 || cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_now: got flags %b idx %0d rep %0d rdy %b required 0000 0 0 1",
                     {ser_o, shift_en, busy, done}, bit_idx, rep_cnt, cfg_ready);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (done !== 1'b0 || shift_en !== 1'b0 || cfg_ready !== 1'b1) begin
                n_err++;
                $display("FAIL rstmid_after%0d: got done %b en %b rdy %b required 0 0 1", i, done, shift_en, cfg_ready);
            end
        end
    endtask

    task automatic test_abort_final_bit();
        logic [0:0] e;
        push_exp(12'b10, 2, 1);
        start_cfg(12'b10, 4'd2, 8'd1);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (shift_en !== 1'b1 || ser_o !== e) begin
                n_err++;
                $display("FAIL abfin_bit%0d: got en %b ser %b required 1 %b", i, shift_en, ser_o, e);
            end
            if (i == 1) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (done !== 1'b0 || shift_en !== 1'b0 || cfg_ready !== 1'b1) begin
                n_err++;
                $display("FAIL abfin_after%0d: got done %b en %b rdy %b required 0 0 1", i, done, shift_en, cfg_ready);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [CHAIN_W-1:0] p;
        int l, le, r;
        logic [0:0] e;
        for (int k = 0; k < 6; k++) begin
            p  = CHAIN_W'($urandom_range(0, 4095));
            l  = $urandom_range(0, 12);
            le = eff_len(l);
            r  = $urandom_range(1, 3);
            push_exp(p, le, r);
            abort = (k == 0);
            start_cfg(p, LEN_W'(l), REP_W'(r));
            abort = 1'b0;
            for (int i = 0; i < le * r; i++) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (shift_en !== 1'b1 || ser_o !== e || bit_idx !== LEN_W'(i % le)) begin
                    n_err++;
                    $display("FAIL b2b%0d_bit%0d: got en %b ser %b idx %0d required 1 %b %0d",
                             k, i, shift_en, ser_o, bit_idx, e, i % le);
                end
                tick();
            end
            n_cmp++;
            if (done !== 1'b1 || rep_cnt !== REP_W'(r)) begin
                n_err++;
                $display("FAIL b2b%0d_done: got done %b rep %0d required 1 %0d", k, done, rep_cnt, r);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_pattern = '0;
        cfg_len = '0;
        cfg_reps = '0;
        abort = 1'b0;
        test_reset();
        test_finite();
        test_len0();
        test_abort_continuous();
        test_len1_wrap();
        test_cfg_while_busy();
        test_reset_mid_run();
        test_abort_final_bit();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_gen_ctrl.md
SEQ_GEN_CTRL -- requirements
Module: seq_gen_ctrl

Interface
REQ-001 Parameter: CHAIN_W, 12, bit length of the downstream 12-stage shift chain and width of the pattern.
REQ-002 Parameter: LEN_W, 4, width of the length field; SHALL satisfy 2**LEN_W > CHAIN_W.
REQ-003 Parameter: REP_W, 8, width of the repetition field and counter.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 cfg_valid  in  1  a configuration is offered.
REQ-008 cfg_ready  out  1  the controller accepts a configuration.
REQ-009 cfg_pattern  in  CHAIN_W  pattern bits, sent MSB-first starting at bit cfg_len-1.
REQ-010 cfg_len  in  LEN_W  pattern length 1..CHAIN_W; 0 means CHAIN_W.
REQ-011 cfg_reps  in  REP_W  repetitions; 0 means continuous until abort.
REQ-012 abort  in  1  stop the current run.
REQ-013 ser_o  out  1  serial bit to the shift-chain data input.
REQ-014 shift_en  out  1  the ser_o bit is valid this cycle.
REQ-015 busy  out  1  the controller is in RUN.
REQ-016 done  out  1  one-cycle pulse when a finite run completes.
REQ-017 bit_idx  out  LEN_W  index of the current bit within the pattern.
REQ-018 rep_cnt  out  REP_W  number of completed repetitions.

Function
REQ-019 FSM states: IDLE, RUN, DONE.
REQ-020 IDLE: cfg_ready=1; on cfg_valid&cfg_ready, latch pattern, effective length and reps, clear bit_idx and rep_cnt, and go to RUN.
REQ-021 cfg_ready SHALL be 0 in RUN and DONE; cfg_valid in those states is ignored and nothing is latched.
REQ-022 Latency: in the first cycle after the handshake, shift_en=1 and ser_o=pattern[len-1].
REQ-023 RUN, each cycle:
  - shift_en=1
  - ser_o=pattern[len-1-bit_idx]
  - bit_idx increments.
REQ-024 Wrap-around: at bit_idx==len-1, bit_idx returns to 0 and rep_cnt increments.
  - With reps=0, rep_cnt wraps modulo 2**REP_W.
REQ-025 With reps!=0, the wrap at rep_cnt==reps-1 moves to DONE; exactly len*reps bits carry shift_en=1.
REQ-026 DONE: done=1 and shift_en=0 for exactly one cycle, then IDLE.
REQ-027 With len=1, the same bit repeats each cycle and rep_cnt increments every cycle.
REQ-028 abort in RUN: next cycle IDLE with shift_en=0 and no done pulse.
  - abort has priority over completion on the final bit.
  - abort in IDLE or DONE has no effect.
REQ-029 ser_o, shift_en, busy and done SHALL be registered; no combinational path from inputs to them.
REQ-030 ser_o SHALL hold its last value when shift_en=0.
REQ-031 The outputs update on the rising edge, so they are stable for half a cycle before the downstream chain samples on the falling edge.

Reset
REQ-032 rst=1 SHALL immediately force:
  - state IDLE
  - ser_o=0, shift_en=0, busy=0, done=0
  - bit_idx=0, rep_cnt=0
  - cfg_ready=1
  - latched pattern, length and reps = 0.
REQ-033 rst asserted mid-RUN SHALL abandon the run with no done pulse; after release, the block waits for a new handshake.

Structure
REQ-034 Package seq_gen_pkg SHALL hold CHAIN_W, LEN_W, REP_W defaults and the FSM state enumeration.
REQ-035 The block SHALL be a single module with no sub-module; counters and the FSM are inline.

Verification
REQ-036 Test 1, finite run.
  - Stimulus: pattern=12'b000000101101, len=6, reps=2.
  - Response: ser_o=1,0,1,1,0,1,1,0,1,1,0,1 over 12 shift_en cycles; done on the 13th cycle; IDLE on the 14th.
REQ-037 Test 2, length 0.
  - Stimulus: len=0, pattern=12'hA5C, reps=1.
  - Response: 12 bits 1010_0101_1100 MSB-first; then done.
REQ-038 Test 3, continuous run with abort.
  - Stimulus: reps=0, len=3, pattern=3'b110; abort raised on cycle 30 of RUN.
  - Response: shift_en=0 from the next cycle; done never asserts; cfg_ready=1.
REQ-039 Test 4, config while busy.
  - Stimulus: cfg_valid held high during a run with len=4, reps=3.
  - Response: cfg_ready=0 throughout; the run is unchanged; the new config is accepted in the first IDLE cycle.
REQ-040 Test 5, reset mid-run.
  - Stimulus: assert rst on bit 5 of len=8, reps=4.
  - Response: all outputs at reset values immediately; no done pulse.
REQ-041 Test 6, abort on final bit.
  - Stimulus: len=2, reps=1, abort on the 2nd bit.
  - Response: no done pulse; IDLE next cycle.
